// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush arbiter: turns load-use, dcache-miss and branch-flush requests into
// per-stage write enables, with a dcache stall watchdog, protocol flag and saturating counters.
module pipeline_stall_ctrl #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 256,
  parameter int WD_W      = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hazard_i,
  input  logic             mem_stall_i,
  input  logic             branch_flush_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             idex_we_o,
  output logic             exmem_we_o,
  output logic             memwb_we_o,
  output logic             hang_o,
  output logic             proto_err_o,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] mem_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_FREEZE, HANG} state_t;

  state_t           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             hang_q, hang_d;
  logic             proto_q, proto_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             trip;

  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    hang_d        = hang_q;
    proto_d       = proto_q;
    lu_cnt_d      = lu_cnt_q;
    mem_cnt_d     = mem_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    trip          = 1'b0;
    pc_we_o       = 1'b0;
    ifid_we_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    idex_we_o     = 1'b0;
    exmem_we_o    = 1'b0;
    memwb_we_o    = 1'b0;

    // Reset must force every enable low even though the state register already reads RUN.
    if (!rst_i && state_q != HANG) begin
      if (mem_stall_i) begin
        trip    = (wd_q == WD_W'(MAX_STALL - 1));
        wd_d    = wd_q + 1'b1;
        state_d = trip ? HANG : MEM_FREEZE;
        if (trip) hang_d = 1'b1;
        if (mem_cnt_q != '1) mem_cnt_d = mem_cnt_q + 1'b1;
      end else if (hazard_i) begin
        idex_bubble_o = 1'b1;
        idex_we_o     = 1'b1;
        exmem_we_o    = 1'b1;
        memwb_we_o    = 1'b1;
        wd_d          = '0;
        state_d       = LU_BUBBLE;
        if (state_q == LU_BUBBLE) proto_d = 1'b1;
        if (lu_cnt_q != '1) lu_cnt_d = lu_cnt_q + 1'b1;
      end else begin
        pc_we_o      = 1'b1;
        ifid_we_o    = 1'b1;
        idex_we_o    = 1'b1;
        exmem_we_o   = 1'b1;
        memwb_we_o   = 1'b1;
        ifid_flush_o = branch_flush_i;
        wd_d         = '0;
        state_d      = RUN;
        if (branch_flush_i && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wd_q        <= '0;
      hang_q      <= 1'b0;
      proto_q     <= 1'b0;
      lu_cnt_q    <= '0;
      mem_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      hang_q      <= hang_d;
      proto_q     <= proto_d;
      lu_cnt_q    <= lu_cnt_d;
      mem_cnt_q   <= mem_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hang_o      = hang_q;
  assign proto_err_o = proto_q;
  assign lu_cnt_o    = lu_cnt_q;
  assign mem_cnt_o   = mem_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: small counters and a short watchdog so saturation
// and hang are reachable; a rule-level model is compared every cycle, plus literal spot checks.
module tb_pipeline_stall_ctrl;
  localparam int CNT_W     = 3;
  localparam int MAX_STALL = 4;
  localparam int WD_W      = 2;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hz = 1'b0, ms = 1'b1, br = 1'b0;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we, memwb_we;
  logic hang, perr;
  logic [CNT_W-1:0] lu_cnt, mem_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // model state
  int  m_run = 0;
  bit  m_lu_last = 1'b0;
  bit  m_hang = 1'b0;
  bit  m_perr = 1'b0;
  int  m_lu = 0, m_mem = 0, m_fl = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL), .WD_W(WD_W)) dut (
    .clk_i(clk), .rst_i(rst), .hazard_i(hz), .mem_stall_i(ms), .branch_flush_i(br),
    .pc_we_o(pc_we), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush),
    .idex_bubble_o(idex_bubble), .idex_we_o(idex_we), .exmem_we_o(exmem_we),
    .memwb_we_o(memwb_we), .hang_o(hang), .proto_err_o(perr),
    .lu_cnt_o(lu_cnt), .mem_cnt_o(mem_cnt), .flush_cnt_o(flush_cnt)
  );

  // {pc, ifid, flush, bubble, idex, exmem, memwb}
  function automatic logic [6:0] exp_ctrl();
    if (rst || m_hang || ms) return 7'b0000000;
    if (hz) return 7'b0001111;
    return {2'b11, br, 4'b0111};
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_lu_last = 1'b0; m_hang = 1'b0; m_perr = 1'b0;
      m_lu = 0; m_mem = 0; m_fl = 0;
    end else if (!m_hang) begin
      if (ms) begin
        m_run = m_run + 1;
        m_mem = sat(m_mem);
        m_lu_last = 1'b0;
        if (m_run >= MAX_STALL) m_hang = 1'b1;
      end else begin
        m_run = 0;
        if (hz) begin
          if (m_lu_last) m_perr = 1'b1;
          m_lu = sat(m_lu);
          m_lu_last = 1'b1;
        end else begin
          m_lu_last = 1'b0;
          if (br) m_fl = sat(m_fl);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctrl", {9'd0, pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we, memwb_we},
          {9'd0, exp_ctrl()});
      chk("hang", {15'd0, hang}, {15'd0, m_hang});
      chk("proto_err", {15'd0, perr}, {15'd0, m_perr});
      chk("lu_cnt", 16'(lu_cnt), 16'(m_lu));
      chk("mem_cnt", 16'(mem_cnt), 16'(m_mem));
      chk("flush_cnt", 16'(flush_cnt), 16'(m_fl));
    end
  end

  task automatic cyc(input logic m, input logic h, input logic b);
    @(posedge clk); #1;
    ms = m; hz = h; br = b;
    @(negedge clk);
  endtask

  function automatic logic [15:0] ctrl_now();
    return {9'd0, pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we, memwb_we};
  endfunction

  initial begin
    // T1: reset held during a mem stall
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("t1_rst_ctrl", ctrl_now(), 16'h00);
    chk("t1_rst_mem_cnt", 16'(mem_cnt), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0; ms = 1'b0;
    @(negedge clk);
    chk("t1_run_ctrl", ctrl_now(), 16'h67);

    // T2: single load-use bubble
    cyc(0, 1, 0);
    chk("t2_bubble_ctrl", ctrl_now(), 16'h0F);
    cyc(0, 0, 0);
    chk("t2_after_ctrl", ctrl_now(), 16'h67);
    chk("t2_lu_cnt", 16'(lu_cnt), 16'd1);
    chk("t2_proto", {15'd0, perr}, 16'd0);

    // T3: mem stall dominates, then hazard right after freeze is legal
    repeat (3) begin
      cyc(1, 1, 1);
      chk("t3_freeze_ctrl", ctrl_now(), 16'h00);
    end
    cyc(0, 1, 0);
    chk("t3_bubble_ctrl", ctrl_now(), 16'h0F);
    chk("t3_mem_cnt", 16'(mem_cnt), 16'd3);
    cyc(0, 0, 0);
    chk("t3_proto", {15'd0, perr}, 16'd0);

    // T4: branch flush alone, then masked by hazard
    cyc(0, 0, 1);
    chk("t4_flush_ctrl", ctrl_now(), 16'h77);
    cyc(0, 1, 1);
    chk("t4_masked_ctrl", ctrl_now(), 16'h0F);
    chk("t4_flush_cnt", 16'(flush_cnt), 16'd1);
    cyc(0, 0, 0);
    chk("t4_flush_cnt_hold", 16'(flush_cnt), 16'd1);

    // T6: back-to-back hazard, then counter saturation
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("t6_second_bubble", ctrl_now(), 16'h0F);
    cyc(0, 0, 0);
    chk("t6_proto", {15'd0, perr}, 16'd1);
    repeat (4) cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("t6_lu_sat", 16'(lu_cnt), 16'd7);

    // T5: 3-cycle stall is safe, 4-cycle stall hangs
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("t5_no_hang", {15'd0, hang}, 16'd0);
    repeat (4) cyc(1, 0, 0);
    chk("t5_hang_pre", {15'd0, hang}, 16'd0);
    cyc(0, 0, 0);
    chk("t5_hang", {15'd0, hang}, 16'd1);
    chk("t5_hang_ctrl", ctrl_now(), 16'h00);
    cyc(0, 0, 1);
    chk("t5_hang_ctrl2", ctrl_now(), 16'h00);
    chk("t5_flush_frozen", 16'(flush_cnt), 16'd1);

    // reset out of HANG
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_hang_clr", {15'd0, hang}, 16'd0);
    chk("rst_ctrl", ctrl_now(), 16'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ctrl", ctrl_now(), 16'h77);
    cyc(0, 0, 0);
    chk("post_rst_flush_cnt", 16'(flush_cnt), 16'd1);
    chk("post_rst_mem_cnt", 16'(mem_cnt), 16'd0);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected finish before 20000");
    $fatal(1);
  end
endmodule
